rhythm_judge_ctrl: RTL and testbench
====================================

# rhythm_judge_ctrl

Game controller that sequences the note-lane shifter of the LED-matrix rhythm game. It owns song selection and start/finish flow and drives the shifter's `song` select. It judges red/blue drum presses against the note at the judge column and issues the one-cycle `delete` that clears a hit note. It keeps combo, max combo and score for the display logic.

## Interface
Parameters:
- `COUNT_CYCLES`, 25_000_000: clk cycles per countdown beat.
- `GREAT_LO`, 2: lowest `offset` graded GREAT.
- `GREAT_HI`, 4: highest `offset` graded GREAT.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `red_button` in 1: raw red drum, asynchronous, active-high.
- `blue_button` in 1: raw blue drum, asynchronous, active-high.
- `yellow_button` in 1: raw start/confirm, asynchronous.
- `song_sw` in 2: song choice; 0 means none.
- `note_R_judge` in 1: red note present at judge column.
- `note_B_judge` in 1: blue note present at judge column.
- `offset` in 3: shifter sub-step, 0..6.
- `finish` in 1: shifter end-of-song level.
- `song` out 2: song select to shifter.
- `delete` out 1: one-cycle clear of judge column.
- `judge_evt` out 2: one-cycle pulse; 0 none, 1 GREAT, 2 GOOD, 3 MISS.
- `combo` out 8: current combo.
- `max_combo` out 8: best combo this song.
- `score` out 16: score this song.
- `countdown` out 2: beats remaining, 3..1; 0 otherwise.
- `state` out 2: FSM state.

## Operation
- Buttons: 2-FF synchronizer, then rising-edge detect. Press edges are `r_ev`, `b_ev`, `y_ev`.
- States: SELECT=0, COUNTDOWN=1, PLAY=2, RESULT=3.
- SELECT:
  - `song`=0.
  - On `y_ev` with `song_sw`≠0: latch `song_sw` and clear combo, max_combo, score.
  - Then go to COUNTDOWN (or PLAY if countdown is compiled out).
  - `y_ev` with `song_sw`=0 is ignored.
- COUNTDOWN:
  - `song`=0.
  - `countdown` runs 3,2,1, each beat lasting COUNT_CYCLES.
  - After the third beat, go to PLAY.
- PLAY:
  - `song`=latched value.
  - Rising `finish` → RESULT.
- RESULT:
  - `song` held, so the shifter stays in FINISH.
  - Score and combo are frozen.
  - `y_ev` → SELECT.
- Judging (PLAY only) uses `note_R_judge`, `note_B_judge` and `offset` registered one cycle (`nr_q`, `nb_q`, `off_q`).
  - `r_ev` with `nr_q`, or `b_ev` with `nb_q` → hit.
  - Hit grade: GREAT if GREAT_LO ≤ `off_q` ≤ GREAT_HI, else GOOD.
  - Press of the wrong colour while a note is present → MISS, no delete.
  - Press with no note present → no effect.
  - Both edges in the same cycle: only the colour matching the present note is judged, and it is a hit.
- Pass-by miss: a shift event (`off_q`=6, `offset`=0) while the judge column holds an unhit note → MISS.
- Hit and shift event in the same cycle:
  - The hit is scored.
  - No pass-by miss is raised.
  - `delete` is suppressed, so the newly arrived note is not cleared.
- Arithmetic:
  - Hit base points: GREAT +2, GOOD +1.
  - Bonus: +1 if combo ≥ 10 before the increment.
  - `score` saturates at 0xFFFF.
  - On a hit, `combo` increments, saturating at 255.
  - On MISS, `combo` goes to 0.
  - `max_combo` = max(`max_combo`, new combo).

## Timing
- Reset: all outputs 0; state SELECT.
- Reset asserted mid-song returns everything to SELECT immediately. `song` drops to 0, and the shifter itself is reset by the same `rst`.
- Press latency: raw press to edge takes 3 cycles. The judge decision lands on the following edge; `judge_evt`, `delete`, `combo` and `score` all update on it.
  - `delete` is high exactly 1 cycle.
  - There is at most one `judge_evt` per cycle.
- Transitions take effect on the clk edge after the qualifying event.
- `countdown` decrements every COUNT_CYCLES cycles.

## Configuration
- `COUNTDOWN_EN` defined: COUNTDOWN state and beat counter are present.
- Undefined:
  - SELECT goes directly to PLAY.
  - `countdown` is tied to 0.
  - COUNT_CYCLES is unused.

## Structure
- Package `rhythm_pkg`:
  - State encodings.
  - `judge_evt` codes.
  - GREAT/GOOD/bonus point constants.
  - Combo bonus threshold (10).
- Sub-module `button_sync_edge` (2-FF sync plus rising-edge pulse), instantiated three times.

## Test plan
- Yellow with `song_sw`=0 → stays SELECT, `song`=0. Then `song_sw`=2 plus yellow → COUNTDOWN 3,2,1 (COUNT_CYCLES=4), then PLAY with `song`=2.
- `nr_q`=1, `off_q`=3, red press → `judge_evt`=1, `delete` 1 cycle, combo 1, score 2. At `off_q`=6 → `judge_evt`=2, score +1.
- Ten consecutive GREAT hits, then an eleventh GREAT → score +3 on the eleventh, combo 11, max_combo 11.
- Blue press while `nr_q`=1 → MISS, combo 0, no `delete`, max_combo unchanged.
- Red note present, `offset` goes 6→0 without a press → MISS. Red press in that same cycle → hit scored, `delete` stays 0.
- `finish` rises → RESULT, score frozen. Yellow → SELECT. Assert `rst` mid-PLAY → all outputs 0.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm game judge controller.
package rhythm_pkg;

    localparam int unsigned SONG_W   = 2;
    localparam int unsigned OFFSET_W = 3;
    localparam int unsigned COMBO_W  = 8;
    localparam int unsigned SCORE_W  = 16;

    typedef enum logic [1:0] {
        ST_SELECT    = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_GREAT = 2'd1,
        EVT_GOOD  = 2'd2,
        EVT_MISS  = 2'd3
    } judge_evt_t;

    localparam logic [SCORE_W-1:0]  PTS_GREAT      = SCORE_W'(2);
    localparam logic [SCORE_W-1:0]  PTS_GOOD       = SCORE_W'(1);
    localparam logic [SCORE_W-1:0]  PTS_BONUS      = SCORE_W'(1);
    localparam logic [COMBO_W-1:0]  COMBO_BONUS_TH = COMBO_W'(10);
    localparam logic [COMBO_W-1:0]  COMBO_MAX      = '1;
    localparam logic [OFFSET_W-1:0] OFFSET_LAST    = OFFSET_W'(6);

    // Saturating score addition.
    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a registered rising-edge pulse.
module button_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Synchronize the raw input and emit one pulse per rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            ev      <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            ev      <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/rhythm_judge_ctrl.sv
// Rhythm game flow controller and drum judge.
// Optional feature macro: COUNTDOWN_EN (adds the 3-2-1 countdown state).
module rhythm_judge_ctrl
    import rhythm_pkg::*;
#(
    parameter int unsigned COUNT_CYCLES = 25_000_000,
    parameter int unsigned GREAT_LO     = 2,
    parameter int unsigned GREAT_HI     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                red_button,
    input  logic                blue_button,
    input  logic                yellow_button,
    input  logic [SONG_W-1:0]   song_sw,
    input  logic                note_R_judge,
    input  logic                note_B_judge,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                finish,
    output logic [SONG_W-1:0]   song,
    output logic                delete,
    output logic [1:0]          judge_evt,
    output logic [COMBO_W-1:0]  combo,
    output logic [COMBO_W-1:0]  max_combo,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          countdown,
    output logic [1:0]          state
);

    localparam logic [OFFSET_W-1:0] GREAT_LO_V = OFFSET_W'(GREAT_LO);
    localparam logic [OFFSET_W-1:0] GREAT_HI_V = OFFSET_W'(GREAT_HI);

    logic r_ev;
    logic b_ev;
    logic y_ev;

    button_sync_edge u_red (
        .clk (clk),
        .rst (rst),
        .btn (red_button),
        .ev  (r_ev)
    );

    button_sync_edge u_blue (
        .clk (clk),
        .rst (rst),
        .btn (blue_button),
        .ev  (b_ev)
    );

    button_sync_edge u_yellow (
        .clk (clk),
        .rst (rst),
        .btn (yellow_button),
        .ev  (y_ev)
    );

    logic                nr_q;
    logic                nb_q;
    logic [OFFSET_W-1:0] off_q;
    logic                finish_q;

    // One-cycle registered view of the shifter's judge column and finish level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nr_q     <= 1'b0;
            nb_q     <= 1'b0;
            off_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            nr_q     <= note_R_judge;
            nb_q     <= note_B_judge;
            off_q    <= offset;
            finish_q <= finish;
        end
    end

    state_t              state_q;
    judge_evt_t          judge_evt_q;
    logic [SONG_W-1:0]   song_q;
    logic                hit_lock;

    logic                shift_c;
    logic                nr_eff_c;
    logic                nb_eff_c;
    logic                hit_c;
    logic                miss_c;
    logic                great_c;
    logic                finish_rise_c;
    logic [SCORE_W-1:0]  pts_c;
    logic [COMBO_W-1:0]  combo_inc_c;

    // Judge decision for the current cycle; a note already hit stays locked until it leaves.
    always_comb begin
        shift_c       = (off_q == OFFSET_LAST) && (offset == '0);
        nr_eff_c      = nr_q & ~hit_lock;
        nb_eff_c      = nb_q & ~hit_lock;
        hit_c         = (r_ev & nr_eff_c) | (b_ev & nb_eff_c);
        miss_c        = (~hit_c & ((r_ev & nb_eff_c) | (b_ev & nr_eff_c)))
                      | (shift_c & (nr_eff_c | nb_eff_c) & ~hit_c);
        great_c       = (off_q >= GREAT_LO_V) && (off_q <= GREAT_HI_V);
        finish_rise_c = finish & ~finish_q;
        pts_c         = great_c ? PTS_GREAT : PTS_GOOD;
        if (combo >= COMBO_BONUS_TH) begin
            pts_c = pts_c + PTS_BONUS;
        end
        combo_inc_c   = (combo == COMBO_MAX) ? combo : combo + COMBO_W'(1);
    end

`ifdef COUNTDOWN_EN
    localparam int unsigned BEAT_W = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(COUNT_CYCLES - 1);

    logic [BEAT_W-1:0] beat_cnt;
    logic [1:0]        countdown_q;
`else
    logic unused_count_cycles;
    assign unused_count_cycles = ^(32'(COUNT_CYCLES));
`endif

    // Game flow FSM with scoring; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SELECT;
            judge_evt_q <= EVT_NONE;
            song_q      <= '0;
            song        <= '0;
            delete      <= 1'b0;
            combo       <= '0;
            max_combo   <= '0;
            score       <= '0;
            hit_lock    <= 1'b0;
`ifdef COUNTDOWN_EN
            beat_cnt    <= '0;
            countdown_q <= 2'd0;
`endif
        end else begin
            delete      <= 1'b0;
            judge_evt_q <= EVT_NONE;
            case (state_q)
                ST_SELECT: begin
                    if (y_ev && (song_sw != '0)) begin
                        song_q    <= song_sw;
                        combo     <= '0;
                        max_combo <= '0;
                        score     <= '0;
                        hit_lock  <= 1'b0;
`ifdef COUNTDOWN_EN
                        state_q     <= ST_COUNTDOWN;
                        countdown_q <= 2'd3;
                        beat_cnt    <= '0;
`else
                        state_q   <= ST_PLAY;
                        song      <= song_sw;
`endif
                    end
                end
`ifdef COUNTDOWN_EN
                ST_COUNTDOWN: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_cnt <= '0;
                        if (countdown_q == 2'd1) begin
                            countdown_q <= 2'd0;
                            state_q     <= ST_PLAY;
                            song        <= song_q;
                        end else begin
                            countdown_q <= countdown_q - 2'd1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
`endif
                ST_PLAY: begin
                    if (finish_rise_c) begin
                        state_q <= ST_RESULT;
                    end
                    if (hit_c) begin
                        judge_evt_q <= great_c ? EVT_GREAT : EVT_GOOD;
                        delete      <= ~shift_c;
                        combo       <= combo_inc_c;
                        score       <= sat_add_score(score, pts_c);
                        if (combo_inc_c > max_combo) begin
                            max_combo <= combo_inc_c;
                        end
                    end else if (miss_c) begin
                        judge_evt_q <= EVT_MISS;
                        combo       <= '0;
                    end
                    if (hit_c && !shift_c) begin
                        hit_lock <= 1'b1;
                    end else if (shift_c || (!nr_q && !nb_q)) begin
                        hit_lock <= 1'b0;
                    end
                end
                ST_RESULT: begin
                    if (y_ev) begin
                        state_q  <= ST_SELECT;
                        song     <= '0;
                        hit_lock <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SELECT;
                    song    <= '0;
                end
            endcase
        end
    end

`ifdef COUNTDOWN_EN
    assign countdown = countdown_q;
`else
    assign countdown = 2'd0;
`endif
    assign state     = state_q;
    assign judge_evt = judge_evt_q;

endmodule

// File: tb/tb_rhythm_judge_ctrl.sv
// Directed bench for rhythm_judge_ctrl: vector table plus multi-cycle sequences.
module tb_rhythm_judge_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        red_button;
    logic        blue_button;
    logic        yellow_button;
    logic [1:0]  song_sw;
    logic        note_R_judge;
    logic        note_B_judge;
    logic [2:0]  offset;
    logic        finish;
    logic [1:0]  song;
    logic        delete;
    logic [1:0]  judge_evt;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [15:0] score;
    logic [1:0]  countdown;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       r;
        logic       b;
        logic       nr;
        logic       nb;
        logic [2:0] off;
        int         evt;
        int         del;
        int         combo;
        int         score;
        int         maxc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    rhythm_judge_ctrl #(
        .COUNT_CYCLES (4),
        .GREAT_LO     (2),
        .GREAT_HI     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .red_button    (red_button),
        .blue_button   (blue_button),
        .yellow_button (yellow_button),
        .song_sw       (song_sw),
        .note_R_judge  (note_R_judge),
        .note_B_judge  (note_B_judge),
        .offset        (offset),
        .finish        (finish),
        .song          (song),
        .delete        (delete),
        .judge_evt     (judge_evt),
        .combo         (combo),
        .max_combo     (max_combo),
        .score         (score),
        .countdown     (countdown),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic r, input logic b, input logic nr,
                        input logic nb, input int off, input int evt, input int del,
                        input int cmb, input int scr, input int maxc);
        vecs[i].r     = r;
        vecs[i].b     = b;
        vecs[i].nr    = nr;
        vecs[i].nb    = nb;
        vecs[i].off   = 3'(off);
        vecs[i].evt   = evt;
        vecs[i].del   = del;
        vecs[i].combo = cmb;
        vecs[i].score = scr;
        vecs[i].maxc  = maxc;
    endtask

    // Yellow press: edge appears 3 cycles after the raw press, state moves on the 4th.
    task automatic press_yellow();
        yellow_button = 1'b1;
        tick(4);
    endtask

    task automatic release_all();
        red_button    = 1'b0;
        blue_button   = 1'b0;
        yellow_button = 1'b0;
        note_R_judge  = 1'b0;
        note_B_judge  = 1'b0;
        tick(4);
    endtask

    initial begin
        //     idx r  b  nr nb off evt del combo score max
        setv( 0, 1, 0, 1, 0, 3,  1,  1,  1,    2,   1);
        setv( 1, 1, 0, 1, 0, 6,  2,  1,  2,    3,   2);
        setv( 2, 1, 0, 1, 0, 2,  1,  1,  3,    5,   3);
        setv( 3, 1, 0, 1, 0, 4,  1,  1,  4,    7,   4);
        setv( 4, 0, 1, 0, 1, 3,  1,  1,  5,    9,   5);
        setv( 5, 1, 0, 1, 0, 3,  1,  1,  6,   11,   6);
        setv( 6, 1, 0, 1, 0, 3,  1,  1,  7,   13,   7);
        setv( 7, 0, 1, 0, 1, 2,  1,  1,  8,   15,   8);
        setv( 8, 1, 0, 1, 0, 4,  1,  1,  9,   17,   9);
        setv( 9, 1, 0, 1, 0, 3,  1,  1, 10,   19,  10);
        setv(10, 1, 0, 1, 0, 3,  1,  1, 11,   22,  11);
        setv(11, 1, 0, 1, 0, 5,  2,  1, 12,   24,  12);
        setv(12, 0, 1, 0, 1, 1,  2,  1, 13,   26,  13);
        setv(13, 0, 1, 1, 0, 3,  3,  0,  0,   26,  13);
        setv(14, 1, 0, 0, 0, 3,  0,  0,  0,   26,  13);
        setv(15, 1, 1, 1, 0, 3,  1,  1,  1,   28,  13);
        setv(16, 1, 1, 0, 1, 0,  2,  1,  2,   29,  13);

        rst           = 1'b1;
        red_button    = 1'b0;
        blue_button   = 1'b0;
        yellow_button = 1'b0;
        song_sw       = 2'd0;
        note_R_judge  = 1'b0;
        note_B_judge  = 1'b0;
        offset        = 3'd0;
        finish        = 1'b0;
        tick(3);
        chk("reset_state", int'(state), 0);
        chk("reset_song", int'(song), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_countdown", int'(countdown), 0);
        rst = 1'b0;
        tick(2);

        // Yellow with no song selected is ignored.
        press_yellow();
        tick(2);
        chk("ignore_y_state", int'(state), 0);
        chk("ignore_y_song", int'(song), 0);
        release_all();

        // Start song 2.
        song_sw = 2'd2;
        press_yellow();
`ifdef COUNTDOWN_EN
        chk("cd_state", int'(state), 1);
        chk("cd_3", int'(countdown), 3);
        chk("cd_song0", int'(song), 0);
        tick(4);
        chk("cd_2", int'(countdown), 2);
        tick(4);
        chk("cd_1", int'(countdown), 1);
        tick(4);
        chk("cd_done", int'(countdown), 0);
`endif
        chk("play_state", int'(state), 2);
        chk("play_song", int'(song), 2);
        chk("play_combo0", int'(combo), 0);
        yellow_button = 1'b0;
        tick(4);

        for (int i = 0; i < NV; i++) begin
            note_R_judge = vecs[i].nr;
            note_B_judge = vecs[i].nb;
            offset       = vecs[i].off;
            red_button   = vecs[i].r;
            blue_button  = vecs[i].b;
            tick(4);
            chk($sformatf("v%0d_evt", i), int'(judge_evt), vecs[i].evt);
            chk($sformatf("v%0d_delete", i), int'(delete), vecs[i].del);
            chk($sformatf("v%0d_combo", i), int'(combo), vecs[i].combo);
            chk($sformatf("v%0d_score", i), int'(score), vecs[i].score);
            chk($sformatf("v%0d_max", i), int'(max_combo), vecs[i].maxc);
            tick(1);
            chk($sformatf("v%0d_delete_1cyc", i), int'(delete), 0);
            chk($sformatf("v%0d_evt_1cyc", i), int'(judge_evt), 0);
            release_all();
        end

        // Pass-by miss: red note leaves the judge column unhit.
        note_R_judge = 1'b1;
        offset       = 3'd6;
        tick(2);
        offset = 3'd0;
        tick(1);
        chk("pass_evt", int'(judge_evt), 3);
        chk("pass_combo", int'(combo), 0);
        chk("pass_delete", int'(delete), 0);
        chk("pass_score", int'(score), 29);
        chk("pass_max", int'(max_combo), 13);
        tick(1);
        chk("pass_evt_1cyc", int'(judge_evt), 0);
        release_all();

        // Hit landing on the same cycle as a shift: scored, no delete, no miss.
        note_R_judge = 1'b1;
        offset       = 3'd6;
        red_button   = 1'b1;
        tick(3);
        offset = 3'd0;
        tick(1);
        chk("hs_evt", int'(judge_evt), 2);
        chk("hs_delete", int'(delete), 0);
        chk("hs_combo", int'(combo), 1);
        chk("hs_score", int'(score), 30);
        tick(1);
        chk("hs_delete_after", int'(delete), 0);
        chk("hs_evt_after", int'(judge_evt), 0);
        release_all();

        // Finish rises: RESULT, score frozen, yellow returns to SELECT.
        finish = 1'b1;
        tick(1);
        chk("result_state", int'(state), 3);
        chk("result_song", int'(song), 2);
        note_R_judge = 1'b1;
        offset       = 3'd3;
        red_button   = 1'b1;
        tick(4);
        chk("result_evt", int'(judge_evt), 0);
        chk("result_score", int'(score), 30);
        chk("result_combo", int'(combo), 1);
        release_all();
        press_yellow();
        chk("back_select", int'(state), 0);
        chk("back_song", int'(song), 0);
        chk("back_score", int'(score), 30);
        release_all();
        finish = 1'b0;

        // Restart with song 1, then reset mid-play.
        song_sw = 2'd1;
        press_yellow();
`ifdef COUNTDOWN_EN
        tick(12);
`endif
        chk("replay_state", int'(state), 2);
        chk("replay_song", int'(song), 1);
        chk("replay_score", int'(score), 0);
        chk("replay_max", int'(max_combo), 0);
        yellow_button = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_song", int'(song), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_evt", int'(judge_evt), 0);
        chk("rst_delete", int'(delete), 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
